seq_restoring_divider: RTL and testbench

- Multi-cycle unsigned integer divider: dividend / divisor -> quotient, remainder; the inverse operation of the team's combinational array multipliers.
- One quotient bit per clock (restoring shift-subtract), start/done handshake.
- Sits beside the multiplier blocks in the arithmetic library; a bench pairs the two for round-trip checks.

---
 rtl/arith_pkg.sv | 20 ++
 rtl/seq_restoring_divider_div_step.sv | 21 ++
 rtl/seq_restoring_divider.sv | 113 +++++++++++
 tb/tb_seq_restoring_divider.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: divider FSM state encoding,
// counter sizing helper and the divide-by-zero quotient constant.
package arith_pkg;

  typedef logic [1:0] div_state_t;

  localparam div_state_t ST_IDLE = 2'd0;
  localparam div_state_t ST_CALC = 2'd1;
  localparam div_state_t ST_DONE = 2'd2;

  localparam int MAX_WIDTH = 32;

  // All-ones quotient reported for x / 0; callers slice it to their width.
  localparam logic [MAX_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

  function automatic int div_cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, compare
// against the divisor and conditionally subtract.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;

  // The restored remainder is always below the divisor, so WIDTH bits hold
  // it; only the shifted value needs the extra bit for the compare.
  assign shifted = {r_in, bit_in};
  assign q_bit   = (shifted >= {1'b0, divisor});
  assign r_out   = q_bit ? (shifted[WIDTH-1:0] - divisor) : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_restoring_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Define SEQ_DIVIDER_ZERO_BYPASS_EN to skip the iterations when divisor == 0.
module seq_restoring_divider
  import arith_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int               CNT_W     = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  div_state_t       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] dvd_reg;
  logic [WIDTH-1:0] dsr_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic             dbz_reg;

  logic [WIDTH-1:0] r_next;
  logic             q_bit;
  logic [WIDTH-1:0] q_next;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .r_in   (r_reg),
    .bit_in (dvd_reg[WIDTH-1]),
    .divisor(dsr_reg),
    .r_out  (r_next),
    .q_bit  (q_bit)
  );

  assign q_next = {q_reg[WIDTH-2:0], q_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            dvd_reg <= dividend;
            dsr_reg <= divisor;
            r_reg   <= '0;
            q_reg   <= '0;
            cnt_reg <= '0;
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
            if (divisor == '0) begin
              state_reg     <= ST_DONE;
              quotient_reg  <= DIV_ZERO_QUOTIENT[WIDTH-1:0];
              remainder_reg <= dividend;
              dbz_reg       <= 1'b1;
            end else begin
              state_reg <= ST_CALC;
            end
`else
            state_reg <= ST_CALC;
`endif
          end
        end
        ST_CALC: begin
          r_reg   <= r_next;
          q_reg   <= q_next;
          dvd_reg <= {dvd_reg[WIDTH-2:0], 1'b0};
          cnt_reg <= cnt_reg + 1'b1;
          // Results are published on the edge that enters DONE so they are
          // already valid in the cycle done is high.
          if (cnt_reg == LAST_ITER) begin
            state_reg     <= ST_DONE;
            quotient_reg  <= q_next;
            remainder_reg <= r_next;
            dbz_reg       <= (dsr_reg == '0);
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_reg == ST_CALC);
  assign done        = (state_reg == ST_DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider (WIDTH=4): directed table,
// multi-cycle corner sequences, exhaustive sweep and random back-to-back runs.
module tb_seq_restoring_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec;
  int n_err;

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } vec_t;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Reference model straight from the arithmetic definition.
  function automatic void ref_div(input int a, input int b, output int q, output int r, output int z);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
      z = 1;
    end else begin
      q = a / b;
      r = a % b;
      z = 0;
    end
  endfunction

  function automatic int exp_latency(input int b);
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
    if (b == 0) return 1;
`endif
    return W + 1;
  endfunction

  function automatic int exp_busy(input int b);
`ifdef SEQ_DIVIDER_ZERO_BYPASS_EN
    if (b == 0) return 0;
`endif
    return W;
  endfunction

  // Issues one request and follows it to done. Returns with the sim at the
  // negedge of the done cycle (lat = 0 if done never came).
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int nbusy);
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    lat      = 0;
    nbusy    = 0;
    for (int k = 1; k <= 40; k++) begin
      if (busy) nbusy++;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_result(input string tag, input int a, input int b, input int lat, input int nbusy);
    int q, r, z;
    ref_div(a, b, q, r, z);
    $display("%s: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", tag, a, b, quotient, remainder, div_by_zero, lat);
    chk({tag, " latency"}, lat, exp_latency(b));
    chk({tag, " busy cycles"}, nbusy, exp_busy(b));
    chk({tag, " quotient"}, quotient, q);
    chk({tag, " remainder"}, remainder, r);
    chk({tag, " div_by_zero"}, div_by_zero, z);
    if (b != 0) begin
      chk({tag, " q*d+r"}, quotient * b + remainder, a);
      chk({tag, " r<d"}, remainder < b, 1);
    end
  endtask

  initial begin
    vec_t vecs[6];
    int lat, nbusy, cnt_done, cnt_busy;

    n_vec    = 0;
    n_err    = 0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    rst_n    = 1'b0;

    vecs[0] = '{a: 4'd13, b: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0};
    vecs[1] = '{a: 4'd15, b: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 4'd7,  q: 4'd0,  r: 4'd0, z: 1'b0};
    vecs[3] = '{a: 4'd15, b: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0};
    vecs[4] = '{a: 4'd7,  b: 4'd9,  q: 4'd0,  r: 4'd7, z: 1'b0};
    vecs[5] = '{a: 4'd9,  b: 4'd0,  q: 4'd15, r: 4'd9, z: 1'b1};

    repeat (3) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    chk("reset div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;

    // Directed table with hold check after each result.
    for (int i = 0; i < 6; i++) begin
      run_div(vecs[i].a, vecs[i].b, lat, nbusy);
      $display("vec%0d: %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", i, vecs[i].a, vecs[i].b,
               quotient, remainder, div_by_zero, lat);
      chk($sformatf("vec%0d latency", i), lat, exp_latency(vecs[i].b));
      chk($sformatf("vec%0d busy cycles", i), nbusy, exp_busy(vecs[i].b));
      chk($sformatf("vec%0d quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d remainder", i), remainder, vecs[i].r);
      chk($sformatf("vec%0d div_by_zero", i), div_by_zero, vecs[i].z);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d done single pulse", i), done, 0);
      chk($sformatf("vec%0d hold quotient", i), quotient, vecs[i].q);
      chk($sformatf("vec%0d hold remainder", i), remainder, vecs[i].r);
    end

    // 14/4 with a second request and operand change during CALC.
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd4;
    @(negedge clk);
    start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd5; divisor = 4'd5;
    @(negedge clk);
    start = 1'b0; dividend = 4'd1; divisor = 4'd1;
    cnt_done = 0;
    for (int k = 0; k < 14; k++) begin
      if (done) begin
        cnt_done++;
        chk("ignored-start quotient", quotient, 3);
        chk("ignored-start remainder", remainder, 2);
        chk("ignored-start div_by_zero", div_by_zero, 0);
      end
      @(negedge clk);
    end
    $display("ignored-start: 14 / 4 -> q=%0d r=%0d dones=%0d", quotient, remainder, cnt_done);
    chk("ignored-start done count", cnt_done, 1);

    // Asynchronous reset two cycles into 11/2.
    @(negedge clk);
    start = 1'b1; dividend = 4'd11; divisor = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre-abort busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    chk("abort div_by_zero", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt_done = 0;
    cnt_busy = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) cnt_done++;
      if (busy) cnt_busy++;
      @(negedge clk);
    end
    $display("abort: 11 / 2 aborted, dones=%0d busy=%0d", cnt_done, cnt_busy);
    chk("abort no done", cnt_done, 0);
    chk("abort no busy", cnt_busy, 0);
    run_div(4'd11, 4'd2, lat, nbusy);
    check_result("post-abort", 11, 2, lat, nbusy);

    // Exhaustive back-to-back sweep.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(W'(a), W'(b), lat, nbusy);
        check_result("sweep", a, b, lat, nbusy);
      end
    end

    // Random requests with random idle gaps.
    for (int i = 0; i < 64; i++) begin
      int a, b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_div(W'(a), W'(b), lat, nbusy);
      check_result("rand", a, b, lat, nbusy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
